// File: rtl/clk_ce_gen.sv
// clk_ce_gen: free-running divider, glitch-free multi-mode CPU clock and per-channel enable strobes
module clk_ce_gen #(
    parameter int CNT_W   = 32,
    parameter int SEL_W   = 5,
    parameter int NUM_CH  = 4,
    parameter int DEB_CYC = 16,
    parameter int STEP_HI = 2
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic [1:0]              mode,
    input  logic [SEL_W-1:0]        fast_sel,
    input  logic [SEL_W-1:0]        slow_sel,
    input  logic                    step_btn,
    input  logic [NUM_CH*SEL_W-1:0] ch_sel,
    output logic [CNT_W-1:0]        clkdiv,
    output logic                    cpu_clk,
    output logic                    cpu_ce,
    output logic [1:0]              act_mode,
    output logic [NUM_CH-1:0]       ch_ce
);
    typedef enum logic [1:0] {FAST, SLOW, STEP, HOLD} mode_e;
    localparam int DW = $clog2(DEB_CYC + 1);
    localparam int SW = $clog2(STEP_HI + 1);

    // Out-of-range taps fold onto the counter MSB
    function automatic logic [SEL_W-1:0] clamp(input logic [SEL_W-1:0] s);
        return (32'(s) >= CNT_W) ? SEL_W'(CNT_W - 1) : s;
    endfunction

    function automatic logic bit_at(input logic [CNT_W-1:0] v, input logic [SEL_W-1:0] t);
        return 1'(v >> t);
    endfunction

    function automatic logic src_of(input mode_e m, input logic [SEL_W-1:0] t,
                                    input logic [CNT_W-1:0] v, input logic sh);
        return (m == FAST || m == SLOW) ? bit_at(v, t) : (m == STEP) ? sh : 1'b0;
    endfunction

    logic [CNT_W-1:0] clkdiv_q;
    mode_e            act_mode_q, req_mode;
    logic [SEL_W-1:0] act_tap_q, req_tap;
    logic             cpu_clk_q, cpu_clk_d, cpu_ce_q;
    logic             req_diff, switch_ok, cur_src, new_src;
    logic             sync1_q, sync2_q, deb_q, deb_flip, step_rise, step_hi_q;
    logic [DW-1:0]    deb_cnt_q;
    logic [SW-1:0]    step_cnt_q;

    // Source selection and the glitch-free switch condition: only swap while both old output and new source are low
    always_comb begin
        req_mode  = mode_e'(mode);
        req_tap   = (req_mode == FAST) ? clamp(fast_sel) : (req_mode == SLOW) ? clamp(slow_sel) : '0;
        req_diff  = (req_mode != act_mode_q) || (req_tap != act_tap_q);
        new_src   = src_of(req_mode, req_tap, clkdiv_q, step_hi_q);
        cur_src   = src_of(act_mode_q, act_tap_q, clkdiv_q, step_hi_q);
        switch_ok = req_diff && !cpu_clk_q && !new_src;
        cpu_clk_d = switch_ok ? 1'b0 : cur_src;
        deb_flip  = (sync2_q != deb_q) && (deb_cnt_q == DW'(DEB_CYC - 1));
        step_rise = deb_flip && sync2_q && (act_mode_q == STEP) && !step_hi_q;
    end

    // Divider counter, CPU clock register and active source
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            clkdiv_q   <= '0;
            cpu_clk_q  <= 1'b0;
            cpu_ce_q   <= 1'b0;
            act_mode_q <= HOLD;
            act_tap_q  <= '0;
        end else begin
            clkdiv_q  <= clkdiv_q + CNT_W'(1);
            cpu_clk_q <= cpu_clk_d;
            cpu_ce_q  <= cpu_clk_d & ~cpu_clk_q;
            if (switch_ok) begin
                act_mode_q <= req_mode;
                act_tap_q  <= req_tap;
            end
        end
    end

    // Step button synchroniser, debouncer and fixed-width high phase
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            sync1_q    <= 1'b0;
            sync2_q    <= 1'b0;
            deb_q      <= 1'b0;
            deb_cnt_q  <= '0;
            step_hi_q  <= 1'b0;
            step_cnt_q <= '0;
        end else begin
            sync1_q   <= step_btn;
            sync2_q   <= sync1_q;
            deb_cnt_q <= (sync2_q == deb_q || deb_flip) ? '0 : deb_cnt_q + DW'(1);
            if (deb_flip)
                deb_q <= sync2_q;
            if (step_rise) begin
                step_hi_q  <= 1'b1;
                step_cnt_q <= '0;
            end else if (step_hi_q) begin
                step_cnt_q <= step_cnt_q + SW'(1);
                if (step_cnt_q == SW'(STEP_HI - 1))
                    step_hi_q <= 1'b0;
            end
        end
    end

    for (genvar c = 0; c < NUM_CH; c++) begin : g_ch
        logic [SEL_W-1:0] sel_req, sel_q;
        logic             tap, prev_q, ce_q;
        assign sel_req = clamp(ch_sel[c*SEL_W +: SEL_W]);
        assign tap     = bit_at(clkdiv_q, sel_req);
        // Rising-edge strobe; a tap change reloads prev and suppresses the strobe
        always_ff @(posedge clk or posedge rst) begin
            if (rst) begin
                sel_q  <= '0;
                prev_q <= 1'b0;
                ce_q   <= 1'b0;
            end else begin
                sel_q  <= sel_req;
                prev_q <= tap;
                ce_q   <= (sel_req == sel_q) & tap & ~prev_q;
            end
        end
        assign ch_ce[c] = ce_q;
    end

    assign clkdiv   = clkdiv_q;
    assign cpu_clk  = cpu_clk_q;
    assign cpu_ce   = cpu_ce_q;
    assign act_mode = act_mode_q;
endmodule

// File: tb/tb_clk_ce_gen.sv
// tb_clk_ce_gen: directed checks of modes, switching, step debounce, channels, wrap and reset
module tb_clk_ce_gen;
    localparam int CNT_W = 8, SEL_W = 5, NUM_CH = 2;

    logic                    clk = 1'b0;
    logic                    rst = 1'b1;
    logic [1:0]              mode = 2'b00;
    logic [SEL_W-1:0]        fast_sel = 5'd2;
    logic [SEL_W-1:0]        slow_sel = 5'd0;
    logic                    step_btn = 1'b0;
    logic [NUM_CH*SEL_W-1:0] ch_sel = {5'd0, 5'd3};
    logic [CNT_W-1:0]        clkdiv;
    logic                    cpu_clk, cpu_ce;
    logic [1:0]              act_mode;
    logic [NUM_CH-1:0]       ch_ce;

    int checks = 0;
    int passed = 0;

    clk_ce_gen #(.CNT_W(CNT_W), .SEL_W(SEL_W), .NUM_CH(NUM_CH), .DEB_CYC(4), .STEP_HI(2)) dut (
        .clk(clk), .rst(rst), .mode(mode), .fast_sel(fast_sel), .slow_sel(slow_sel),
        .step_btn(step_btn), .ch_sel(ch_sel), .clkdiv(clkdiv), .cpu_clk(cpu_clk),
        .cpu_ce(cpu_ce), .act_mode(act_mode), .ch_ce(ch_ce)
    );

    always #5 clk = ~clk;

    function automatic int b(input int v, input int n);
        return (v >> n) & 1;
    endfunction

    task automatic check(input string tag, input int k, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) passed++;
        else $error("FAIL %s@%0d: got %0h want %0h", tag, k, obs, exp);
    endtask

    task automatic press(input int n);
        step_btn = 1'b1;
        for (int j = 1; j <= n; j++) begin
            @(negedge clk);
            check("step_clk", j, cpu_clk, (j == 7 || j == 8));
            check("step_ce", j, cpu_ce, (j == 7));
        end
    endtask

    task automatic release_btn();
        step_btn = 1'b0;
        for (int j = 1; j <= 10; j++) begin
            @(negedge clk);
            check("rel_clk", j, cpu_clk, 0);
            check("rel_ce", j, cpu_ce, 0);
        end
    endtask

    initial begin
        @(negedge clk);
        check("rst_clkdiv", 0, clkdiv, 0);
        check("rst_cpu_clk", 0, cpu_clk, 0);
        check("rst_cpu_ce", 0, cpu_ce, 0);
        check("rst_ch_ce", 0, ch_ce, 0);
        check("rst_act", 0, act_mode, 3);
        @(negedge clk);
        rst = 1'b0;
        // FAST tap 2, then SLOW tap 5 requested with cpu_clk high; ch0 tap3->tap1 at 98
        for (int k = 1; k <= 110; k++) begin
            @(negedge clk);
            check("clkdiv", k, clkdiv, k);
            check("act", k, act_mode, (k >= 18) ? 1 : 0);
            check("cpu_clk", k, cpu_clk, (k <= 17) ? b(k - 1, 2) : b(k - 1, 5));
            check("cpu_ce", k, cpu_ce, (k == 5 || k == 13 || k == 33 || k == 97));
            check("ch_ce", k, ch_ce, {1'(k % 2 == 0),
                  1'((k <= 98) ? ((k - 1) % 16 == 8) : (k >= 100 && k % 4 == 3))});
            if (k == 13) begin
                mode = 2'b01;
                slow_sel = 5'd5;
            end
            if (k == 98) ch_sel[4:0] = 5'd1;
            if (k == 110) begin
                ch_sel[9:5] = 5'd7;
                mode = 2'b00;
                fast_sel = 5'd20;
            end
        end
        // SLOW->FAST with clamped tap 7; ch1 tap 7 across the counter wrap
        for (int k = 111; k <= 400; k++) begin
            @(negedge clk);
            check("clkdiv", k, clkdiv, k % 256);
            check("act", k, act_mode, (k < 258) ? 1 : 0);
            check("cpu_clk", k, cpu_clk, (k < 258) ? b(k - 1, 5) : b(k - 1, 7));
            check("cpu_ce", k, cpu_ce, (k == 161 || k == 225 || k == 385));
            check("ch_ce", k, ch_ce, {1'(k % 256 == 129), 1'(k % 4 == 3)});
        end
        mode = 2'b10;
        for (int k = 401; k <= 520; k++) begin
            @(negedge clk);
            check("act", k, act_mode, (k >= 514) ? 2 : 0);
            check("cpu_clk", k, cpu_clk, (k >= 514) ? 0 : b(k - 1, 7));
            check("cpu_ce", k, cpu_ce, 0);
        end
        // Short press: three cycles is below the debounce threshold
        step_btn = 1'b1;
        for (int j = 1; j <= 12; j++) begin
            @(negedge clk);
            if (j == 3) step_btn = 1'b0;
            check("short_clk", j, cpu_clk, 0);
            check("short_ce", j, cpu_ce, 0);
        end
        press(20);
        release_btn();
        press(20);
        release_btn();
        // Reset asserted while the step high phase is driving cpu_clk
        press(7);
        rst = 1'b1;
        step_btn = 1'b0;
        #1;
        check("arst_clkdiv", 0, clkdiv, 0);
        check("arst_cpu_clk", 0, cpu_clk, 0);
        check("arst_cpu_ce", 0, cpu_ce, 0);
        check("arst_ch_ce", 0, ch_ce, 0);
        check("arst_act", 0, act_mode, 3);
        @(negedge clk);
        rst = 1'b0;
        check("post_rst_act", 0, act_mode, 3);
        @(negedge clk);
        check("post_rst_act", 1, act_mode, 2);
        check("post_rst_clkdiv", 1, clkdiv, 1);
        check("post_rst_clk", 1, cpu_clk, 0);
        $display("%0d/%0d checks passed", passed, checks);
        $finish;
    end
endmodule
